// File: rtl/tff_arb_pkg.sv
// Shared definitions for the TFF toggle arbiter: FSM encoding and gap counter sizing.
package tff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int GAP_W = 4;
  typedef logic [GAP_W-1:0] gap_cnt_t;

endpackage

// File: rtl/tff_toggle_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                pos;

  always_comb begin
    // Rotate so that bit 0 is the requester just after ptr, encode, then un-rotate.
    dbl   = {req, req} >> (int'(ptr) + 1);
    rot   = dbl[NREQ-1:0];
    found = |rot;
    pos   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    idx = IDW'((int'(ptr) + 1 + pos) % NREQ);
  end

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter granting one requester's toggle mask onto a shared TFF bank,
// followed by a programmable hold-off gap.
//
//   state | meaning
//   IDLE  | waiting for a request; winner and mask captured on the decision edge
//   GRANT | one cycle: ack and t_en driven for the captured winner
//   HOLD  | GAP idle cycles, requests ignored
module tff_toggle_arbiter
  import tff_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      t_en,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  gap_cnt_t        gap_cnt, gap_cnt_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [WIDTH-1:0] t_en_nxt;
  logic [IDW-1:0]  grant_id_nxt;
  logic            busy_nxt;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gap_cnt_nxt  = gap_cnt;
    ack_nxt      = '0;
    t_en_nxt     = '0;
    grant_id_nxt = grant_id;
    unique case (state)
      IDLE: begin
        // Outputs are loaded here so they are registered during the GRANT cycle.
        if (pick_found) begin
          state_nxt    = GRANT;
          ack_nxt      = NREQ'(1) << pick_idx;
          t_en_nxt     = mask[int'(pick_idx)*WIDTH +: WIDTH];
          grant_id_nxt = pick_idx;
        end
      end
      GRANT: begin
        ptr_nxt     = grant_id;
        gap_cnt_nxt = '0;
        state_nxt   = (GAP > 0) ? HOLD : IDLE;
      end
      HOLD: begin
        if (gap_cnt < gap_cnt_t'(GAP)) gap_cnt_nxt = gap_cnt + 1'b1;
        if (gap_cnt >= gap_cnt_t'(GAP - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IDW'(NREQ - 1);
      gap_cnt  <= '0;
      ack      <= '0;
      t_en     <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gap_cnt  <= gap_cnt_nxt;
      ack      <= ack_nxt;
      t_en     <= t_en_nxt;
      grant_id <= grant_id_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule
